// File: rtl/mux_tree_pkg.sv
// Shared sizing helpers for the pipelined N:1 mux tree.
// Gives the tree depth and the node count at each level.
package mux_tree_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

   function automatic int levels(input int n);
      return clog2(n);
   endfunction

   // Node count at level k is ceil(n / 2^k).
   function automatic int nodes_at(input int n, input int k);
      return (n + (1 << k) - 1) >> k;
   endfunction

endpackage

// File: rtl/mux2_level.sv
// One level of the mux tree: pairs of nodes reduced by sel_i[0], odd last node passed up.
// With REG=1 the level is a handshake stage that holds {valid, nodes, sel, err} under back-pressure.
module mux2_level
   import mux_tree_pkg::*;
#(
   parameter int NI  = 2,
   parameter int W   = 8,
   parameter int SW  = 1,
   parameter int REG = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          vld_i,
   output logic                          rdy_o,
   input  logic [NI*W-1:0]               nodes_i,
   input  logic [SW-1:0]                 sel_i,
   input  logic                          err_i,
   output logic                          vld_o,
   input  logic                          rdy_i,
   output logic [nodes_at(NI, 1)*W-1:0]  nodes_o,
   output logic [SW-1:0]                 sel_o,
   output logic                          err_o
);

   localparam int NO = nodes_at(NI, 1);

   logic [NO*W-1:0] mux_d;
   logic [SW-1:0]   sel_d;

   always_comb begin
      mux_d = '0;
      for (int j = 0; j < NI / 2; j++) begin
         mux_d[j*W +: W] = sel_i[0] ? nodes_i[(2*j+1)*W +: W] : nodes_i[(2*j)*W +: W];
      end
      if (NI % 2 == 1) begin
         mux_d[(NO-1)*W +: W] = nodes_i[(NI-1)*W +: W];
      end
   end

   // The consumed select bit is dropped; later levels see their bit at position 0.
   assign sel_d = sel_i >> 1;

   if (REG != 0) begin : g_reg
      logic            vld_q;
      logic [NO*W-1:0] nodes_q;
      logic [SW-1:0]   sel_q;
      logic            err_q;
      logic            load;

      assign load = !vld_q || rdy_i;

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q   <= 1'b0;
            nodes_q <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
         end else if (load) begin
            vld_q   <= vld_i;
            nodes_q <= mux_d;
            sel_q   <= sel_d;
            err_q   <= err_i;
         end
      end

      assign rdy_o   = load;
      assign vld_o   = vld_q;
      assign nodes_o = nodes_q;
      assign sel_o   = sel_q;
      assign err_o   = err_q;
   end else begin : g_comb
      logic unused_clk;

      assign unused_clk = clk ^ rst;
      assign rdy_o      = rdy_i;
      assign vld_o      = vld_i;
      assign nodes_o    = mux_d;
      assign sel_o      = sel_d;
      assign err_o      = err_i;
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// Parametrised N:1 word multiplexer built as a binary tree of mux2_level stages,
// with valid/ready flow control and per-transaction out-of-range flagging.
module mux_tree_pipe
   import mux_tree_pkg::*;
#(
   parameter int N    = 9,
   parameter int W    = 8,
   parameter int PIPE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N*W-1:0]        in_data,
   input  logic [clog2(N)-1:0]   in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [W-1:0]          out_data,
   output logic                  out_err,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int            SW    = clog2(N);
   localparam int            L     = levels(N);
   localparam logic [SW:0]   N_LIM = (SW+1)'(N);

   logic [L:0]          vld_w;
   logic [L:0]          rdy_w;
   logic [L:0]          err_w;
   logic [L:0][SW-1:0]  sel_w;
   logic                unused_sel;

   // Range check at accept; the flag then travels with the transaction.
   assign vld_w[0] = in_valid;
   assign sel_w[0] = in_sel;
   assign err_w[0] = ({1'b0, in_sel} >= N_LIM);
   assign in_ready = rdy_w[0];
   assign rdy_w[L] = out_ready;

   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int NI   = nodes_at(N, k);
      localparam int NO   = nodes_at(N, k + 1);
      localparam int LREG = ((PIPE != 0) || (k == L - 1)) ? 1 : 0;

      logic [NI*W-1:0] nodes_in;
      logic [NO*W-1:0] nodes_out;

      if (k == 0) begin : g_src
         assign nodes_in = in_data;
      end else begin : g_src
         assign nodes_in = g_lvl[k-1].nodes_out;
      end

      mux2_level #(
         .NI  (NI),
         .W   (W),
         .SW  (SW),
         .REG (LREG)
      ) u_lvl (
         .clk     (clk),
         .rst     (rst),
         .vld_i   (vld_w[k]),
         .rdy_o   (rdy_w[k]),
         .nodes_i (nodes_in),
         .sel_i   (sel_w[k]),
         .err_i   (err_w[k]),
         .vld_o   (vld_w[k+1]),
         .rdy_i   (rdy_w[k+1]),
         .nodes_o (nodes_out),
         .sel_o   (sel_w[k+1]),
         .err_o   (err_w[k+1])
      );
   end

   // All select bits are consumed by the last level.
   assign unused_sel = ^sel_w[L];

   assign out_valid = vld_w[L];
   assign out_err   = err_w[L];
   assign out_data  = err_w[L] ? '0 : g_lvl[L-1].nodes_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: N=9/W=8/PIPE=1 and N=4/W=16/PIPE=0 instances,
// table vectors, hand-written corner sequences and a queue-based random scoreboard.
module tb_mux_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;

   logic [71:0] a_in_data;
   logic [3:0]  a_in_sel;
   logic        a_in_valid, a_in_ready;
   logic [7:0]  a_out_data;
   logic        a_out_err, a_out_valid, a_out_ready;

   logic [63:0] b_in_data;
   logic [1:0]  b_in_sel;
   logic        b_in_valid, b_in_ready;
   logic [15:0] b_out_data;
   logic        b_out_err, b_out_valid, b_out_ready;

   mux_tree_pipe #(.N(9), .W(8), .PIPE(1)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_data   (a_in_data),
      .in_sel    (a_in_sel),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .out_data  (a_out_data),
      .out_err   (a_out_err),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready)
   );

   mux_tree_pipe #(.N(4), .W(16), .PIPE(0)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_data   (b_in_data),
      .in_sel    (b_in_sel),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .out_data  (b_out_data),
      .out_err   (b_out_err),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: the selected channel for in-range selects, zero otherwise.
   function automatic logic [7:0] ref_a_d(input logic [71:0] d, input logic [3:0] s);
      if (s < 4'd9) return d[int'(s)*8 +: 8];
      return 8'h00;
   endfunction

   typedef struct packed {
      logic [7:0] d;
      logic       e;
   } exp_t;

   exp_t       a_q[$];
   logic       a_prev_stall = 1'b0;
   logic [7:0] a_prev_d;
   logic       a_prev_e;
   int         cyc = 0;
   int         n_out = 0;
   bit         obs_ready;
   int         out_cyc[$];
   logic [7:0] got_d[$];
   logic       got_e[$];

   // One clock cycle on DUT A: drive, check outputs against the scoreboard, advance.
   task automatic cyc_a(input logic v, input logic [3:0] s, input logic [71:0] d,
                        input logic ordy, output bit acc);
      exp_t x;
      a_in_valid  = v;
      a_in_sel    = s;
      a_in_data   = d;
      a_out_ready = ordy;
      #1;
      obs_ready = a_in_ready;
      check("a_in_ready", 64'(a_in_ready), 64'(ordy || (a_q.size() < 4)));
      if (a_prev_stall) begin
         check("a_hold_valid", 64'(a_out_valid), 64'(1));
         check("a_hold_data", 64'(a_out_data), 64'(a_prev_d));
         check("a_hold_err", 64'(a_out_err), 64'(a_prev_e));
      end
      a_prev_stall = a_out_valid && !ordy;
      a_prev_d     = a_out_data;
      a_prev_e     = a_out_err;
      if (a_q.size() == 0) begin
         check("a_idle_valid", 64'(a_out_valid), 64'(0));
      end else if (a_out_valid && ordy) begin
         x = a_q.pop_front();
         check("a_out_data", 64'(a_out_data), 64'(x.d));
         check("a_out_err", 64'(a_out_err), 64'(x.e));
         n_out++;
         out_cyc.push_back(cyc);
         got_d.push_back(a_out_data);
         got_e.push_back(a_out_err);
      end
      acc = v && a_in_ready;
      if (acc) begin
         x.d = ref_a_d(d, s);
         x.e = (s >= 4'd9);
         a_q.push_back(x);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   bit          b_prev_acc = 1'b0;
   logic [15:0] b_prev_d;

   // One clock cycle on DUT B: out_ready held high, so each accept must emerge next cycle.
   task automatic cyc_b(input logic v, input logic [1:0] s, input logic [63:0] d);
      b_in_valid  = v;
      b_in_sel    = s;
      b_in_data   = d;
      b_out_ready = 1'b1;
      #1;
      check("b_in_ready", 64'(b_in_ready), 64'(1));
      check("b_out_valid", 64'(b_out_valid), 64'(b_prev_acc));
      if (b_prev_acc) begin
         check("b_out_data", 64'(b_out_data), 64'(b_prev_d));
         check("b_out_err", 64'(b_out_err), 64'(0));
      end
      b_prev_acc = v && b_in_ready;
      b_prev_d   = d[int'(s)*16 +: 16];
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] sel;
      logic [7:0] exp_d;
      logic       exp_e;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit          acc;
      int          n0, c0, acc_n, sent;
      logic [71:0] tdata;
      logic [95:0] r96;
      logic [63:0] r64;

      for (int i = 0; i < 9; i++) tbl[i] = '{4'(i), 8'(8'h10 + i), 1'b0};
      tbl[9]  = '{4'd9,  8'h00, 1'b1};
      tbl[10] = '{4'd15, 8'h00, 1'b1};

      rst         = 1'b1;
      a_in_data   = '0;
      a_in_sel    = '0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      b_in_data   = '0;
      b_in_sel    = '0;
      b_in_valid  = 1'b0;
      b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
      check("rst_a_out_data", 64'(a_out_data), 64'(0));
      check("rst_a_out_err", 64'(a_out_err), 64'(0));
      check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
      check("rst_b_out_data", 64'(b_out_data), 64'(0));
      rst = 1'b0;
      #1;
      check("rst_a_in_ready", 64'(a_in_ready), 64'(1));
      check("rst_b_in_ready", 64'(b_in_ready), 64'(1));

      // Table: in_data[i] = 0x10+i, back-to-back selects including the odd node and out-of-range.
      for (int i = 0; i < 9; i++) tdata[i*8 +: 8] = 8'(8'h10 + i);
      out_cyc.delete();
      got_d.delete();
      got_e.delete();
      n0 = n_out;
      c0 = cyc;
      for (int i = 0; i < 11; i++) begin
         cyc_a(1'b1, tbl[i].sel, tdata, 1'b1, acc);
         check("tbl_accept", 64'(acc), 64'(1));
      end
      for (int c = 0; c < 20 && (n_out - n0) < 11; c++) cyc_a(1'b0, 4'd0, tdata, 1'b1, acc);
      check("tbl_count", 64'(n_out - n0), 64'(11));
      for (int i = 0; i < got_d.size() && i < 11; i++) begin
         check($sformatf("tbl_data[%0d]", i), 64'(got_d[i]), 64'(tbl[i].exp_d));
         check($sformatf("tbl_err[%0d]", i), 64'(got_e[i]), 64'(tbl[i].exp_e));
         check($sformatf("tbl_cycle[%0d]", i), 64'(out_cyc[i]), 64'(c0 + 4 + i));
      end

      // Back-pressure: 6 transactions, out_ready low until the pipe has stalled 5 cycles.
      n0   = n_out;
      sent = 0;
      for (int c = 0; c < 40 && (n_out - n0) < 6; c++) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         cyc_a(sent < 6, 4'($urandom_range(0, 8)), r96[71:0], c >= 9, acc);
         if (acc) sent++;
         if (c >= 4 && c <= 8) check("bp_in_ready_stall", 64'(obs_ready), 64'(0));
      end
      check("bp_delivered", 64'(n_out - n0), 64'(6));

      // Random traffic with random back-pressure against the queue scoreboard.
      n0    = n_out;
      acc_n = 0;
      for (int c = 0; c < 20000 && acc_n < 1000; c++) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         cyc_a($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), r96[71:0],
               $urandom_range(0, 3) != 0, acc);
         if (acc) acc_n++;
      end
      check("rand_accepted", 64'(acc_n), 64'(1000));
      for (int c = 0; c < 50 && a_q.size() > 0; c++) cyc_a(1'b0, 4'd0, 72'd0, 1'b1, acc);
      check("rand_delivered", 64'(n_out - n0), 64'(1000));
      check("rand_queue_empty", 64'(a_q.size()), 64'(0));

      // Reset with three transactions in flight: none may emerge afterwards.
      for (int i = 0; i < 3; i++) begin
         r96 = {$urandom(), $urandom(), $urandom()};
         cyc_a(1'b1, 4'($urandom_range(0, 8)), r96[71:0], 1'b1, acc);
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      rst         = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(a_out_valid), 64'(0));
      check("midrst_in_ready", 64'(a_in_ready), 64'(1));
      a_q.delete();
      a_prev_stall = 1'b0;
      for (int i = 0; i < 10; i++) cyc_a(1'b0, 4'd0, 72'd0, 1'b1, acc);

      // PIPE=0 instance: single-cycle latency, random selects.
      for (int i = 0; i < 200; i++) begin
         r64 = {$urandom(), $urandom()};
         cyc_b($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), r64);
      end
      cyc_b(1'b0, 2'd0, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
